// File: rtl/bulk_ep_out_pktfifo.sv
// Single-clock packet buffer for a USB bulk OUT endpoint.
// Sits between the packet decoder (s_*) and the user AXI-Stream sink (m_*).
// In packet mode only committed packets become visible, bad packets are rolled
// back, and a packet too large to ever fit is discarded. ready_read_o is the
// ACK/NAK hint: set while a full MAX_PACKET packet still fits.
// Ports:
//   clock, reset        sole clock, synchronous active-high reset
//   xfer_i              OUT token seen; re-evaluates ready_read_o
//   ready_read_o        room for one MAX_PACKET packet
//   s_tvalid_i/s_tready_o/s_tlast_i/s_tuser_i/s_tdata_i   upstream stream
//   m_tvalid_o/m_tready_i/m_tlast_o/m_tdata_o             downstream stream
//   level_o             occupied entries (committed + uncommitted)
//   status_full_o       storage full
//   status_drop_o       one-cycle pulse when a packet is discarded
module bulk_ep_out_pktfifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ABITS       = 11,
  parameter int unsigned MAX_PACKET  = 512,
  parameter int unsigned PACKET_MODE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             xfer_i,
  output logic             ready_read_o,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic             s_tuser_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic [ABITS:0]   level_o,
  output logic             status_full_o,
  output logic             status_drop_o
);

  localparam int unsigned PW    = ABITS + 1;
  localparam int unsigned DEPTH = 2 ** ABITS;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] MAXP_P  = PW'(MAX_PACKET);
  localparam logic          PKT     = (PACKET_MODE != 0);

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH:0]   rd_data_q;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    cm_dly_q;
  logic             dropping_q, dropping_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [PW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             drop_q, drop_d;
  logic             rr_q, rr_d;

  logic [PW-1:0]    used_cur, used_d, free_d;
  logic             full_cur, drop_now, beat, mem_we, load;

  // Pointer, commit, drop and output-register next state.
  always_comb begin
    used_cur   = wr_ptr_q - rd_ptr_q;
    full_cur   = (used_cur == DEPTH_P);
    // Storage filled by a single uncommitted packet: it can never fit, discard it.
    drop_now   = PKT & (dropping_q | (full_cur & (cm_ptr_q == rd_ptr_q)));
    s_tready_o = ~full_cur | drop_now;
    beat       = s_tvalid_i & s_tready_o;
    mem_we     = beat & ~drop_now;
    // cm_dly_q lags one edge so the registered read has seen the last write.
    load       = (rd_ptr_q != cm_dly_q) & (~m_valid_q | m_tready_i);

    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dropping_d = dropping_q;
    drop_d     = 1'b0;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;

    if (drop_now) begin
      wr_ptr_d   = cm_ptr_q;
      dropping_d = 1'b1;
      if (beat & s_tlast_i) begin
        dropping_d = 1'b0;
        drop_d     = 1'b1;
      end
    end else if (beat) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (!PKT) begin
        cm_ptr_d = wr_ptr_q + PW'(1);
      end else if (s_tlast_i) begin
        if (s_tuser_i) begin
          wr_ptr_d = cm_ptr_q;
          drop_d   = 1'b1;
        end else begin
          cm_ptr_d = wr_ptr_q + PW'(1);
        end
      end
    end

    if (load) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      m_valid_d = 1'b1;
      m_last_d  = rd_data_q[WIDTH];
      m_data_d  = rd_data_q[WIDTH-1:0];
    end else if (m_tready_i) begin
      m_valid_d = 1'b0;
    end

    used_d  = wr_ptr_d - rd_ptr_d;
    free_d  = DEPTH_P - used_d;
    level_d = used_d;
    full_d  = (used_d == DEPTH_P);

    // Endpoint ACK/NAK hint.
    rr_d = rr_q;
    if (xfer_i) begin
      rr_d = (free_d >= MAXP_P);
    end
    if (beat && s_tlast_i && (free_d < MAXP_P)) begin
      rr_d = 1'b0;
    end
    if (full_d) begin
      rr_d = 1'b0;
    end
  end

  // Storage write and synchronous read of the entry at the next read pointer.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[ABITS-1:0]] <= {s_tlast_i, s_tdata_i};
    end
    rd_data_q <= mem_q[rd_ptr_d[ABITS-1:0]];
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cm_dly_q   <= '0;
      dropping_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      drop_q     <= 1'b0;
      rr_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cm_dly_q   <= cm_ptr_q;
      dropping_q <= dropping_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
      level_q    <= level_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
      rr_q       <= rr_d;
    end
  end

  assign m_tvalid_o    = m_valid_q;
  assign m_tlast_o     = m_last_q;
  assign m_tdata_o     = m_data_q;
  assign level_o       = level_q;
  assign status_full_o = full_q;
  assign status_drop_o = drop_q;
  assign ready_read_o  = rr_q;

endmodule

// File: tb/tb_bulk_ep_out_pktfifo.sv
// Bench for bulk_ep_out_pktfifo: a 16-entry packet-mode instance (u_pk) and a
// 16-entry streaming-mode instance (u_st).
module tb_bulk_ep_out_pktfifo;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       xfer = 1'b0;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       rdy_fix = 1'b0, rdy_rnd = 1'b0, rand_rdy = 1'b0;
  logic       m_tready;
  assign m_tready = rand_rdy ? rdy_rnd : rdy_fix;

  logic       ready_read, s_tready, m_tvalid, m_tlast, status_full, status_drop;
  logic [7:0] m_tdata;
  logic [4:0] level;

  logic       st_tvalid = 1'b0, st_mready = 1'b0;
  logic       st_rr, st_tready, st_mvalid, st_mlast, st_full, st_drop;
  logic [7:0] st_mdata;
  logic [4:0] st_level;

  bulk_ep_out_pktfifo #(.WIDTH(8), .ABITS(4), .MAX_PACKET(8), .PACKET_MODE(1)) u_pk (
    .clock(clock), .reset(reset), .xfer_i(xfer), .ready_read_o(ready_read),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tlast_i(s_tlast),
    .s_tuser_i(s_tuser), .s_tdata_i(s_tdata),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tlast_o(m_tlast), .m_tdata_o(m_tdata),
    .level_o(level), .status_full_o(status_full), .status_drop_o(status_drop));

  bulk_ep_out_pktfifo #(.WIDTH(8), .ABITS(4), .MAX_PACKET(8), .PACKET_MODE(0)) u_st (
    .clock(clock), .reset(reset), .xfer_i(xfer), .ready_read_o(st_rr),
    .s_tvalid_i(st_tvalid), .s_tready_o(st_tready), .s_tlast_i(s_tlast),
    .s_tuser_i(s_tuser), .s_tdata_i(s_tdata),
    .m_tvalid_o(st_mvalid), .m_tready_i(st_mready), .m_tlast_o(st_mlast), .m_tdata_o(st_mdata),
    .level_o(st_level), .status_full_o(st_full), .status_drop_o(st_drop));

  always @(posedge clock) rdy_rnd <= 1'($urandom_range(0, 1));

  // Observed downstream beats {tlast, data} and drop pulses.
  logic [8:0] outq[$];
  int         drops = 0;
  always @(negedge clock) begin
    if (m_tvalid && m_tready) outq.push_back({m_tlast, m_tdata});
    if (status_drop) drops++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
  endtask

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
    int k;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tuser = user;
    k = 0;
    forever begin
      @(negedge clock);
      if (s_tready) break;
      k++;
      if (k > 2000) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base, input logic bad);
    for (int i = 0; i < len; i++)
      send_beat(base + 8'(i), (i == len - 1), bad && (i == len - 1));
  endtask

  typedef struct {
    int         len;
    bit         bad;
    logic [7:0] base;
    int         exp_beats;
    int         exp_drops;
  } vec_t;
  vec_t vecs[7];

  logic [8:0] exp_q[$];

  initial begin
    int ob, od, k, len, nbad;
    bit bad;
    logic [7:0] d;

    vecs[0] = '{len: 4,  bad: 1'b1, base: 8'h01, exp_beats: 0,  exp_drops: 1};
    vecs[1] = '{len: 2,  bad: 1'b0, base: 8'h21, exp_beats: 2,  exp_drops: 0};
    vecs[2] = '{len: 1,  bad: 1'b0, base: 8'h30, exp_beats: 1,  exp_drops: 0};
    vecs[3] = '{len: 16, bad: 1'b0, base: 8'h40, exp_beats: 16, exp_drops: 0};
    vecs[4] = '{len: 20, bad: 1'b0, base: 8'h80, exp_beats: 0,  exp_drops: 1};
    vecs[5] = '{len: 8,  bad: 1'b0, base: 8'hC0, exp_beats: 8,  exp_drops: 0};
    vecs[6] = '{len: 5,  bad: 1'b1, base: 8'hE0, exp_beats: 0,  exp_drops: 1};

    // Reset values.
    do_reset();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_level", level, 0);
    chk("rst_full", status_full, 0);
    chk("rst_drop", status_drop, 0);
    chk("rst_ready_read", ready_read, 1);
    chk("rst_s_tready", s_tready, 1);

    // Good 4-beat packet: latency two edges after tlast, then 1 beat/cycle.
    rdy_fix = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'h11 + 8'(i), (i == 3), 1'b0);
    chk("lat_edgeN", m_tvalid, 0);
    wait_cyc(1);
    chk("lat_edgeN1", m_tvalid, 0);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      chk($sformatf("t1_valid%0d", i), m_tvalid, 1);
      chk($sformatf("t1_data%0d", i), m_tdata, 'h11 + i);
      chk($sformatf("t1_last%0d", i), m_tlast, (i == 3));
    end
    wait_cyc(1);
    chk("t1_valid_end", m_tvalid, 0);
    chk("t1_level_end", level, 0);

    // Table of packets, drained with m_tready=1.
    for (int v = 0; v < 7; v++) begin
      ob = outq.size(); od = drops;
      send_pkt(vecs[v].len, vecs[v].base, vecs[v].bad);
      wait_cyc(30);
      chk($sformatf("vec%0d_beats", v), outq.size() - ob, vecs[v].exp_beats);
      chk($sformatf("vec%0d_drops", v), drops - od, vecs[v].exp_drops);
      chk($sformatf("vec%0d_level", v), level, 0);
      chk($sformatf("vec%0d_s_tready", v), s_tready, 1);
      if (outq.size() - ob == vecs[v].exp_beats)
        for (int i = 0; i < vecs[v].exp_beats; i++)
          chk($sformatf("vec%0d_beat%0d", v, i), outq[ob + i],
              {(i == vecs[v].len - 1), vecs[v].base + 8'(i)});
    end

    // Backpressured fill: one entry sits in the output register, outside level.
    do_reset();
    rdy_fix = 1'b0;
    ob = outq.size();
    send_pkt(8, 8'h50, 1'b0);
    wait_cyc(3);
    chk("bp_rr_after1", ready_read, 1);
    chk("bp_level_after1", level, 7);
    chk("bp_full_after1", status_full, 0);
    send_pkt(8, 8'h58, 1'b0);
    wait_cyc(1);
    chk("bp_rr_after2", ready_read, 0);
    chk("bp_level_after2", level, 15);
    chk("bp_full_after2", status_full, 0);
    send_pkt(1, 8'h60, 1'b0);
    wait_cyc(1);
    chk("bp_full_after3", status_full, 1);
    chk("bp_level_after3", level, 16);
    chk("bp_s_tready_full", s_tready, 0);
    xfer = 1'b1; wait_cyc(1); xfer = 1'b0;
    chk("bp_rr_xfer_full", ready_read, 0);
    rdy_fix = 1'b1;
    wait_cyc(30);
    chk("bp_drained", outq.size() - ob, 17);
    chk("bp_rr_no_xfer", ready_read, 0);
    xfer = 1'b1; wait_cyc(1); xfer = 1'b0;
    chk("bp_rr_xfer_empty", ready_read, 1);
    chk("bp_full_clear", status_full, 0);

    // Streaming mode: a single beat without tlast is visible two edges later.
    do_reset();
    st_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0; s_tuser = 1'b0;
    @(negedge clock);
    chk("st_tready", st_tready, 1);
    @(posedge clock); #1;
    st_tvalid = 1'b0;
    wait_cyc(1);
    chk("st_valid_N1", st_mvalid, 0);
    wait_cyc(1);
    chk("st_valid_N2", st_mvalid, 1);
    chk("st_data", st_mdata, 'hA5);
    chk("st_last", st_mlast, 0);

    // Reset mid-packet with data buffered and the output stalled.
    do_reset();
    rdy_fix = 1'b0;
    send_pkt(3, 8'h61, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(8'h64 + 8'(i), 1'b0, 1'b0);
    wait_cyc(2);
    chk("mid_valid_before", m_tvalid, 1);
    chk("mid_level_before", level, 5);
    reset = 1'b1;
    wait_cyc(1);
    chk("mid_valid_after", m_tvalid, 0);
    chk("mid_level_after", level, 0);
    chk("mid_rr_after", ready_read, 1);
    reset = 1'b0;
    ob = outq.size();
    rdy_fix = 1'b1;
    wait_cyc(20);
    chk("mid_no_stale", outq.size() - ob, 0);

    // Randomized packets against a packet-level model: good packets reappear
    // in order, bad ones vanish with one drop pulse each.
    do_reset();
    rand_rdy = 1'b1;
    exp_q.delete();
    ob = outq.size(); od = drops; nbad = 0;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 16);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) nbad++;
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        if ($urandom_range(0, 3) == 0) wait_cyc(1);
        send_beat(d, (i == len - 1), (i == len - 1) ? bad : 1'($urandom_range(0, 1)));
        if (!bad) exp_q.push_back({(i == len - 1), d});
      end
    end
    k = 0;
    while ((outq.size() - ob < exp_q.size()) && (k < 3000)) begin
      wait_cyc(1);
      k++;
    end
    wait_cyc(10);
    chk("rnd_beat_count", outq.size() - ob, exp_q.size());
    chk("rnd_drops", drops - od, nbad);
    chk("rnd_level", level, 0);
    if (outq.size() - ob == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++)
        chk($sformatf("rnd_beat%0d", i), outq[ob + i], exp_q[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
